axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter.sv | 147 ++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-requester (instruction/data) AXI4 read-channel arbiter with one outstanding transaction.
// Ties alternate away from the previous owner; burst length is checked against rlast.
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] i_araddr,
    input  logic [7:0]        i_arlen,
    input  logic              i_arvalid,
    output logic              i_arready,
    output logic [DATA_W-1:0] i_rdata,
    output logic [1:0]        i_rresp,
    output logic              i_rlast,
    output logic              i_rvalid,
    input  logic              i_rready,

    input  logic [ADDR_W-1:0] d_araddr,
    input  logic [7:0]        d_arlen,
    input  logic              d_arvalid,
    output logic              d_arready,
    output logic [DATA_W-1:0] d_rdata,
    output logic [1:0]        d_rresp,
    output logic              d_rlast,
    output logic              d_rvalid,
    input  logic              d_rready,

    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [1:0]        m_arburst,
    output logic [2:0]        m_arsize,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,

    output logic [1:0]        gnt,
    output logic              len_err,
    output logic [1:0]        state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and arready here depends only on arvalid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] araddr_q;
    logic [7:0]        arlen_q;
    logic [7:0]        beat_cnt_q;
    logic [1:0]        gnt_q;
    logic              last_owner_q;   // 1 = D owned the previous transaction
    logic              len_err_q;

    logic win_i, win_d, sel_rready, r_hs;

    assign win_i      = i_arvalid & (~d_arvalid | last_owner_q);
    assign win_d      = d_arvalid & (~i_arvalid | ~last_owner_q);
    assign sel_rready = (gnt_q[0] & i_rready) | (gnt_q[1] & d_rready);
    assign r_hs       = (state_q == DATA) & m_rvalid & sel_rready;

    assign m_araddr  = araddr_q;
    assign m_arlen   = arlen_q;
    assign m_arvalid = (state_q == ADDR);
    assign m_arburst = 2'b01;
    assign m_arsize  = 3'($clog2(DATA_W / 8));
    assign gnt       = gnt_q;
    assign len_err   = len_err_q;
    assign state_dbg = state_q;

    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;
    assign i_rresp = m_rresp;
    assign d_rresp = m_rresp;
    assign i_rlast = m_rlast;
    assign d_rlast = m_rlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_arready = 1'b0;
        d_arready = 1'b0;
        m_rready  = 1'b0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        case (state_q)
            IDLE: begin
                i_arready = win_i;
                d_arready = win_d;
                if (win_i | win_d) state_d = ADDR;
            end
            ADDR: begin
                if (m_arready) state_d = DATA;
            end
            DATA: begin
                m_rready = sel_rready;
                i_rvalid = gnt_q[0] & m_rvalid;
                d_rvalid = gnt_q[1] & m_rvalid;
                if (r_hs && m_rlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            araddr_q     <= '0;
            arlen_q      <= '0;
            beat_cnt_q   <= '0;
            gnt_q        <= 2'b00;
            last_owner_q <= 1'b1;
            len_err_q    <= 1'b0;
        end else begin
            if (state_q == IDLE && (win_i || win_d)) begin
                araddr_q   <= win_i ? i_araddr : d_araddr;
                arlen_q    <= win_i ? i_arlen : d_arlen;
                gnt_q      <= {win_d, win_i};
                beat_cnt_q <= '0;
            end
            if (r_hs) begin
                beat_cnt_q <= beat_cnt_q + 8'd1;
                // Early rlast and missing rlast on the final counted beat are both errors.
                if (m_rlast != (beat_cnt_q == arlen_q)) len_err_q <= 1'b1;
                if (m_rlast) begin
                    last_owner_q <= gnt_q[1];
                    gnt_q        <= 2'b00;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized self-checking bench for axi_rd_arbiter: a transaction-level arbitration model
// plus an expected-beat queue predicts grants, forwarded beats and the sticky length error.
module tb_axi_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [AW-1:0] i_araddr, d_araddr, m_araddr;
  logic [7:0]    i_arlen, d_arlen, m_arlen;
  logic          i_arvalid, d_arvalid, i_arready, d_arready;
  logic [DW-1:0] i_rdata, d_rdata, m_rdata;
  logic [1:0]    i_rresp, d_rresp, m_rresp;
  logic          i_rlast, d_rlast, m_rlast;
  logic          i_rvalid, d_rvalid, i_rready, d_rready;
  logic          m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]    m_arburst;
  logic [2:0]    m_arsize;
  logic [1:0]    gnt;
  logic          len_err;
  logic [1:0]    state_dbg;

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rresp(d_rresp), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_arburst(m_arburst), .m_arsize(m_arsize),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .gnt(gnt), .len_err(len_err), .state_dbg(state_dbg)
  );

  int n_total = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];
  bit last_owner_m;   // 1 = D owned the last completed transaction
  bit len_err_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    i_araddr = '0; i_arlen = '0; i_arvalid = 1'b0; i_rready = 1'b0;
    d_araddr = '0; d_arlen = '0; d_arvalid = 1'b0; d_rready = 1'b0;
    m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
  endtask

  task automatic model_reset();
    last_owner_m = 1'b1;
    len_err_m = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, gnt, 2'b00);
    check({tag, "_arvalid"}, m_arvalid, 1'b0);
    check({tag, "_araddr"}, m_araddr, 32'h0);
    check({tag, "_arlen"}, m_arlen, 8'h0);
    check({tag, "_rready"}, m_rready, 1'b0);
    check({tag, "_rvalid"}, {i_rvalid, d_rvalid}, 2'b00);
    check({tag, "_len_err"}, len_err, 1'b0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // One full read transaction; called one step after a rising edge with the DUT idle.
  // nb < 0 means the slave sends arlen+1 beats; abort_at >= 0 pulses reset at that beat.
  task automatic txn(input bit req_i, input bit req_d, input logic [31:0] ai, input logic [31:0] ad,
                     input logic [7:0] li, input logic [7:0] ld, input int nb, input int stall,
                     input int abort_at);
    bit win_d, rdy, done;
    logic [31:0] wa;
    logic [7:0] wl;
    int beats, st, c;
    win_d = req_d && (!req_i || !last_owner_m);
    wa = win_d ? ad : ai;
    wl = win_d ? ld : li;
    beats = (nb < 0) ? int'(wl) + 1 : nb;
    i_arvalid = req_i; i_araddr = ai; i_arlen = li;
    d_arvalid = req_d; d_araddr = ad; d_arlen = ld;
    @(negedge clk);
    check("arready", {d_arready, i_arready}, {win_d, !win_d});
    check("gnt_idle", gnt, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    check("m_arvalid", m_arvalid, 1'b1);
    check("m_araddr", m_araddr, wa);
    check("m_arlen", m_arlen, wl);
    check("m_arconst", {m_arburst, m_arsize}, {2'b01, 3'd2});
    check("gnt_owner", gnt, {win_d, !win_d});
    check("arready_busy", {d_arready, i_arready}, 2'b00);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("m_arvalid_hold", {m_arvalid, m_araddr}, {1'b1, wa});
    end
    @(posedge clk); #1 m_arready = 1'b1;
    @(posedge clk); #1 m_arready = 1'b0;
    for (int k = 0; k < beats; k++) begin
      repeat ($urandom_range(0, 1)) begin
        m_rvalid = 1'b0;
        @(negedge clk);
        check("rvalid_gap", {d_rvalid, i_rvalid}, 2'b00);
        @(posedge clk); #1;
      end
      m_rvalid = 1'b1;
      m_rdata = $urandom;
      m_rresp = 2'($urandom_range(0, 3));
      m_rlast = (k == beats - 1);
      exp_q.push_back(m_rdata);
      if (k == abort_at) begin
        if (win_d) d_rready = 1'b1; else i_rready = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(posedge clk); #1;
        check("abort_no_beat", {d_rvalid, i_rvalid, m_rready}, 3'b000);
        idle_inputs();
        rst_n = 1'b1;
        model_reset();
        return;
      end
      st = (k == 0) ? stall : $urandom_range(0, stall);
      c = 0;
      done = 1'b0;
      while (!done) begin
        rdy = (c >= st);
        if (win_d) begin d_rready = rdy; i_rready = 1'($urandom_range(0, 1)); end
        else begin i_rready = rdy; d_rready = 1'($urandom_range(0, 1)); end
        @(negedge clk);
        check("rvalid_route", {d_rvalid, i_rvalid}, {win_d, !win_d});
        check("m_rready", m_rready, rdy);
        check("rdata", win_d ? {d_rdata, d_rresp, d_rlast} : {i_rdata, i_rresp, i_rlast},
              {exp_q[0], m_rresp, m_rlast});
        @(posedge clk); #1;
        if (rdy) begin
          void'(exp_q.pop_front());
          done = 1'b1;
        end
        c++;
      end
    end
    idle_inputs();
    last_owner_m = win_d;
    if (beats != int'(wl) + 1) len_err_m = 1'b1;
    @(negedge clk);
    check("gnt_done", gnt, 2'b00);
    check("len_err", len_err, len_err_m);
    check("m_arvalid_done", m_arvalid, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ri, rd;
    idle_inputs();
    rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    check("reset_arready", {d_arready, i_arready}, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    txn(1, 0, 32'h100, 32'h0, 8'd3, 8'd0, -1, 0, -1);

    do_reset();
    txn(1, 1, 32'h200, 32'h300, 8'd1, 8'd2, -1, 0, -1);
    txn(1, 1, 32'h204, 32'h304, 8'd0, 8'd3, -1, 1, -1);
    txn(1, 1, 32'h208, 32'h308, 8'd2, 8'd1, -1, 1, -1);

    txn(0, 1, 32'h0, 32'h400, 8'd0, 8'd2, -1, 3, -1);

    txn(1, 0, 32'h500, 32'h0, 8'd1, 8'd0, 1, 0, -1);
    txn(0, 1, 32'h0, 32'h504, 8'd0, 8'd1, -1, 1, -1);
    do_reset();
    @(negedge clk);
    check("len_err_cleared", len_err, 1'b0);
    @(posedge clk); #1;
    txn(1, 0, 32'h508, 32'h0, 8'd0, 8'd0, 2, 0, -1);

    do_reset();
    txn(1, 0, 32'h600, 32'h0, 8'd3, 8'd0, -1, 0, 1);
    @(posedge clk); #1;
    txn(1, 1, 32'h700, 32'h800, 8'd1, 8'd1, -1, 0, -1);

    for (int n = 0; n < 24; n++) begin
      ri = 1'($urandom_range(0, 1));
      rd = ri ? 1'($urandom_range(0, 1)) : 1'b1;
      txn(ri, rd, $urandom, $urandom, 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
          ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : -1,
          int'($urandom_range(0, 2)), -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
